// File: rtl/metronome_pkg.sv
// Shared types and constants for the metronome click sequencer.
package metronome_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_PLAY} state_e;

  localparam int ACCENT_SHIFT = 8;
  localparam int NORMAL_SHIFT = 6;
  localparam int MIN_PERIOD   = 2;
  localparam int ROM_LATENCY  = 1;
  localparam int SAMPLE_W     = 16;
  // Registered stages between an accepted tick and sample_valid, minus one.
  localparam int LAT_STAGES   = ROM_LATENCY + 1;

  // Per-tick tag riding alongside the ROM read.
  typedef struct packed {
    logic audible;
    logic accent;
  } tag_t;

  function automatic logic signed [SAMPLE_W-1:0] click_scale(
    input logic signed [SAMPLE_W-1:0] s,
    input logic                       accent
  );
    return accent ? (s <<< ACCENT_SHIFT) : (s <<< NORMAL_SHIFT);
  endfunction

endpackage

// File: rtl/metronome_sequencer_beat_counter.sv
// Tick counter, per-beat latches of period and bar length, beat index and accent.
module beat_counter
  import metronome_pkg::*;
#(
  parameter int PERIOD_WIDTH = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable_i,
  input  logic                    tick_i,
  input  logic [PERIOD_WIDTH-1:0] beat_period_i,
  input  logic [3:0]              beats_per_bar_i,
  output logic                    beat_start_o,
  output logic                    beat_pulse_o,
  output logic                    accent_o,
  output logic [3:0]              beat_index_o
);

  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d, period_q, period_d;
  logic [3:0]              bpb_q, idx_q, idx_d;
  logic [4:0]              idx_inc;
  logic                    first_q, accent_q, accent_d, pulse_q;

  assign beat_start_o = enable_i & tick_i & (cnt_q == '0);

  always_comb begin
    period_d = (beat_period_i < PERIOD_WIDTH'(MIN_PERIOD)) ? PERIOD_WIDTH'(MIN_PERIOD)
                                                           : beat_period_i;
    idx_inc  = {1'b0, idx_q} + 5'd1;
    idx_d    = '0;
    // The first beat after enable always lands on the bar start.
    if (!first_q && beats_per_bar_i != '0)
      idx_d = 4'(idx_inc % {1'b0, beats_per_bar_i});
    accent_d = (beats_per_bar_i != '0) && (idx_d == '0);
    cnt_d    = (cnt_q == period_q - PERIOD_WIDTH'(1)) ? '0 : cnt_q + PERIOD_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      period_q <= PERIOD_WIDTH'(MIN_PERIOD);
      bpb_q    <= '0;
      idx_q    <= '0;
      accent_q <= 1'b0;
      first_q  <= 1'b1;
      pulse_q  <= 1'b0;
    end else if (!enable_i) begin
      cnt_q    <= '0;
      period_q <= PERIOD_WIDTH'(MIN_PERIOD);
      bpb_q    <= '0;
      idx_q    <= '0;
      accent_q <= 1'b0;
      first_q  <= 1'b1;
      pulse_q  <= 1'b0;
    end else begin
      pulse_q <= beat_start_o;
      if (beat_start_o) begin
        // Latched period is >= 2, so the count after a beat start is always 1.
        cnt_q    <= PERIOD_WIDTH'(1);
        period_q <= period_d;
        bpb_q    <= beats_per_bar_i;
        idx_q    <= idx_d;
        accent_q <= accent_d;
        first_q  <= 1'b0;
      end else if (tick_i) begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign beat_pulse_o = pulse_q;
  assign accent_o     = accent_q;
  assign beat_index_o = idx_q;

  // Bar length is only consulted through the live input at the next beat;
  // the latched copy documents the value in force for the current beat.
  logic unused_bpb;
  assign unused_bpb = ^bpb_q;

endmodule

// File: rtl/metronome_sequencer.sv
// Metronome click sequencer: walks the click ROM once per beat and scales
// each byte into a signed 16-bit sample, accenting the first beat of a bar.
module metronome_sequencer
  import metronome_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 14,
  parameter int CLICK_LEN    = 12000,
  parameter int PERIOD_WIDTH = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    sample_tick,
  input  logic [PERIOD_WIDTH-1:0] beat_period,
  input  logic [3:0]              beats_per_bar,
  output logic [ADDR_WIDTH-1:0]   rom_addr,
  input  logic [DATA_WIDTH-1:0]   rom_q,
  output logic [15:0]             sample_out,
  output logic                    sample_valid,
  output logic                    beat_pulse,
  output logic [3:0]              beat_index,
  output logic                    playing
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CLICK_LEN - 1);

  state_e                      state_q;
  logic [ADDR_WIDTH-1:0]       addr_q;
  logic                        playing_q;
  logic [LAT_STAGES:0]         vld_pipe;
  logic                        aud0_q;
  tag_t                        tag1_q;
  logic signed [SAMPLE_W-1:0]  sample_q;

  logic                        beat_start, accent;
  logic signed [DATA_WIDTH-1:0] s_raw;
  logic signed [SAMPLE_W-1:0]  s_ext;

  beat_counter #(.PERIOD_WIDTH(PERIOD_WIDTH)) u_beat (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable_i       (enable),
    .tick_i         (sample_tick),
    .beat_period_i  (beat_period),
    .beats_per_bar_i(beats_per_bar),
    .beat_start_o   (beat_start),
    .beat_pulse_o   (beat_pulse),
    .accent_o       (accent),
    .beat_index_o   (beat_index)
  );

  // Offset-binary to two's complement: flip the MSB, then sign-extend.
  assign s_raw = {~rom_q[DATA_WIDTH-1], rom_q[DATA_WIDTH-2:0]};
  assign s_ext = SAMPLE_W'(s_raw);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      playing_q <= 1'b0;
      vld_pipe  <= '0;
      aud0_q    <= 1'b0;
      tag1_q    <= '0;
      sample_q  <= '0;
    end else if (!enable) begin
      // Dropping enable flushes any sample still in flight.
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      playing_q <= 1'b0;
      vld_pipe  <= '0;
      aud0_q    <= 1'b0;
      tag1_q    <= '0;
      sample_q  <= '0;
    end else begin
      vld_pipe       <= {vld_pipe[LAT_STAGES-1:0], sample_tick};
      tag1_q.audible <= aud0_q;
      tag1_q.accent  <= accent;
      if (vld_pipe[LAT_STAGES-1])
        sample_q <= tag1_q.audible ? click_scale(s_ext, tag1_q.accent) : '0;

      if (beat_start) begin
        state_q   <= ST_PLAY;
        addr_q    <= '0;
        playing_q <= 1'b1;
        aud0_q    <= 1'b1;
      end else if (sample_tick) begin
        if (state_q == ST_PLAY && addr_q != LAST_ADDR) begin
          addr_q <= addr_q + ADDR_WIDTH'(1);
          aud0_q <= 1'b1;
        end else begin
          state_q   <= ST_WAIT;
          playing_q <= 1'b0;
          aud0_q    <= 1'b0;
        end
      end else if (state_q == ST_IDLE) begin
        state_q <= ST_WAIT;
      end
    end
  end

  assign rom_addr     = addr_q;
  assign sample_out   = sample_q;
  assign sample_valid = vld_pipe[LAT_STAGES];
  assign playing      = playing_q;

endmodule
